wheel_adc_sampler: RTL and testbench

- Produces the 12-bit `wheel` value consumed by the ship unit.
- Issues periodic single-sample conversion commands to the MAX10 modular ADC over Avalon-ST (command/response), filters the returned samples by block-averaging, applies a deadband, and presents a stable `wheel` word plus an update strobe.
- Sits between the ADC IP instance and the ship/game logic at top level.

---
 rtl/wheel_adc_sampler.sv | 141 ++++++++++++++
 tb/tb_wheel_adc_sampler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wheel_adc_sampler.sv
// Periodic MAX10 ADC sampler: Avalon-ST command/response, block averaging and deadband.
// Define WHEEL_CLAMP_EN to clamp the averaged wheel value to WHEEL_MAX.
module wheel_adc_sampler #(
    parameter int unsigned SAMPLE_DIV = 50000,
    parameter logic [4:0]  CHANNEL    = 5'd1,
    parameter int unsigned AVG_LOG2   = 3,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned DEADBAND   = 2,
    parameter logic [11:0] WHEEL_MAX  = 12'd3855
) (
    input  logic        clk,
    input  logic        resetN,
    output logic        cmd_valid,
    output logic [4:0]  cmd_channel,
    output logic        cmd_sop,
    output logic        cmd_eop,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic [4:0]  rsp_channel,
    input  logic [11:0] rsp_data,
    output logic [11:0] wheel,
    output logic        wheel_upd,
    output logic [7:0]  timeout_cnt
);
    localparam int DATA_W = 12;
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int TMR_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [DATA_W-1:0] DB_LIM   = DATA_W'(DEADBAND);

`ifdef WHEEL_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CMD, WAIT_RSP, ACC, UPDATE} state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [TMR_W-1:0]   tmr;
    logic [CNT_W-1:0]   smp_cnt;
    logic [ACC_W-1:0]   acc;
    logic [DATA_W-1:0]  sample_p0;
    logic               first_done;
    logic               tick, rsp_match, tmr_last;
    logic [DATA_W-1:0]  avg_c;

    function automatic logic [DATA_W-1:0] clamp_avg(input logic [DATA_W-1:0] a);
        return (CLAMP_EN && (a > WHEEL_MAX)) ? WHEEL_MAX : a;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? DATA_W'(-d) : DATA_W'(d);
    endfunction

    assign tick        = (div_cnt == DIV_LAST);
    assign rsp_match   = rsp_valid && (rsp_channel == CHANNEL);
    assign tmr_last    = (tmr == TMR_LAST);
    assign avg_c       = clamp_avg(acc[ACC_W-1:AVG_LOG2]);
    assign cmd_channel = CHANNEL;
    assign cmd_sop     = cmd_valid;
    assign cmd_eop     = cmd_valid;

    always_ff @(posedge clk) begin
        if (!resetN) state <= IDLE;
        else         state <= state_nxt;
    end

    // A matching response in the last timer cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        cmd_valid = 1'b0;
        case (state)
            IDLE:     if (tick) state_nxt = CMD;
            CMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_nxt = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_match)     state_nxt = ACC;
                else if (tmr_last) state_nxt = IDLE;
            end
            ACC:      state_nxt = (smp_cnt == CNT_LAST) ? UPDATE : IDLE;
            UPDATE:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            div_cnt     <= '0;
            tmr         <= '0;
            smp_cnt     <= '0;
            acc         <= '0;
            sample_p0   <= '0;
            first_done  <= 1'b0;
            wheel       <= '0;
            wheel_upd   <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);
            tmr       <= (state == WAIT_RSP) ? tmr + TMR_W'(1) : '0;
            wheel_upd <= 1'b0;
            case (state)
                WAIT_RSP: begin
                    if (rsp_match)     sample_p0   <= rsp_data;
                    else if (tmr_last) timeout_cnt <= sat_inc8(timeout_cnt);
                end
                // ---- stage p0 -> accumulator
                ACC: begin
                    acc     <= acc + ACC_W'(sample_p0);
                    smp_cnt <= smp_cnt + CNT_W'(1);
                end
                // ---- accumulator -> wheel
                UPDATE: begin
                    acc     <= '0;
                    smp_cnt <= '0;
                    if (!first_done || (abs_diff(avg_c, wheel) > DB_LIM)) begin
                        wheel      <= avg_c;
                        wheel_upd  <= 1'b1;
                        first_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wheel_adc_sampler.sv
// Randomized bench for wheel_adc_sampler: the bench plays the ADC and predicts wheel from block averages.
module tb_wheel_adc_sampler;
    localparam int          P_DIV   = 8;
    localparam logic [4:0]  P_CH    = 5'd1;
    localparam int          P_LOG2  = 3;
    localparam int          P_TMO   = 16;
    localparam int          P_DB    = 2;
    localparam int          P_MAX   = 3855;
    localparam int          BLK     = 1 << P_LOG2;

    logic        clk = 1'b0;
    logic        resetN;
    logic        cmd_valid, cmd_sop, cmd_eop, cmd_ready;
    logic [4:0]  cmd_channel, rsp_channel;
    logic        rsp_valid;
    logic [11:0] rsp_data, wheel;
    logic        wheel_upd;
    logic [7:0]  timeout_cnt;

    wheel_adc_sampler #(
        .SAMPLE_DIV(P_DIV), .CHANNEL(P_CH), .AVG_LOG2(P_LOG2),
        .TIMEOUT(P_TMO), .DEADBAND(P_DB), .WHEEL_MAX(12'(P_MAX))
    ) dut (
        .clk(clk), .resetN(resetN),
        .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop),
        .cmd_eop(cmd_eop), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
        .wheel(wheel), .wheel_upd(wheel_upd), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int upd_count = 0;

    // reference model state
    int blk_sum = 0;
    int blk_n = 0;
    int m_wheel = 0;
    bit m_first = 0;
    int exp_cnt = 0;
    bit exp_pulse = 0;
    int exp_tmo = 0;

    always @(posedge clk) if (wheel_upd === 1'b1) upd_count++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_sample(input int d);
        int avg;
        int diff;
        exp_pulse = 0;
        blk_sum += d;
        blk_n++;
        if (blk_n == BLK) begin
            avg = blk_sum / BLK;
`ifdef WHEEL_CLAMP_EN
            if (avg > P_MAX) avg = P_MAX;
`endif
            diff = (avg > m_wheel) ? avg - m_wheel : m_wheel - avg;
            if (!m_first || diff > P_DB) begin
                m_wheel   = avg;
                m_first   = 1;
                exp_pulse = 1;
                exp_cnt++;
            end
            blk_sum = 0;
            blk_n   = 0;
        end
    endfunction

    function automatic void model_reset();
        blk_sum = 0;
        blk_n   = 0;
        m_wheel = 0;
        m_first = 0;
        exp_tmo = 0;
    endfunction

    task automatic wait_cmd();
        int n;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq("cmd_wait", 32'(cmd_valid), 32'd1);
    endtask

    task automatic convert(input logic [11:0] data, input int rdy_dly, input int rsp_dly);
        wait_cmd();
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            check_eq("cmd_hold", 32'({cmd_valid, cmd_sop, cmd_eop, cmd_channel}), 32'h0E1);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check_eq("cmd_single", 32'(cmd_valid), 32'd0);
        repeat (rsp_dly) @(negedge clk);
        rsp_valid   = 1'b1;
        rsp_channel = P_CH;
        rsp_data    = data;
        @(negedge clk);
        rsp_valid = 1'b0;
        model_sample(int'(data));
        repeat (2) @(negedge clk);
        check_eq("wheel", 32'(wheel), 32'(m_wheel));
        check_eq("wheel_upd", 32'(wheel_upd), 32'(exp_pulse));
        @(negedge clk);
        check_eq("upd_pulse_end", 32'(wheel_upd), 32'd0);
        check_eq("upd_count", 32'(upd_count), 32'(exp_cnt));
    endtask

    task automatic block_const(input logic [11:0] data);
        for (int i = 0; i < BLK; i++)
            convert(data, int'($urandom_range(0, 3)), int'($urandom_range(0, P_TMO - 1)));
    endtask

    task automatic block_random();
        int base;
        int v;
        base = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4095)) : m_wheel;
        for (int i = 0; i < BLK; i++) begin
            v = base + int'($urandom_range(0, 8)) - 4;
            if (v < 0) v = 0;
            if (v > 4095) v = 4095;
            convert(12'(v), int'($urandom_range(0, 3)), int'($urandom_range(0, P_TMO - 1)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
        rsp_channel = '0; rsp_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_wheel", 32'(wheel), 32'd0);
        check_eq("rst_wheel_upd", 32'(wheel_upd), 32'd0);
        check_eq("rst_timeout", 32'(timeout_cnt), 32'd0);
        resetN = 1'b1;

        block_const(12'h400);
        check_eq("first_block", 32'(wheel), 32'h400);

        convert(12'h402, 20, 3);
        for (int i = 1; i < BLK; i++) convert(12'h402, 0, int'($urandom_range(0, 5)));
        check_eq("deadband_hold", 32'(wheel), 32'h400);

        for (int i = 0; i < BLK; i++) convert(12'h403, 1, (i == 3) ? P_TMO - 1 : 2);
        check_eq("deadband_move", 32'(wheel), 32'h403);

        // no response, plus a stray response on another channel
        wait_cmd();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        for (int k = 1; k < P_TMO; k++) begin
            @(negedge clk);
            if (k == 2) begin
                rsp_valid = 1'b1; rsp_channel = 5'd2; rsp_data = 12'h123;
            end
            if (k == 3) rsp_valid = 1'b0;
        end
        check_eq("tmo_last_cycle", 32'(timeout_cnt), 32'(exp_tmo));
        @(negedge clk);
        exp_tmo++;
        check_eq("tmo_count", 32'(timeout_cnt), 32'(exp_tmo));
        check_eq("tmo_idle", 32'(cmd_valid), 32'd0);
        check_eq("tmo_wheel", 32'(wheel), 32'(m_wheel));

        for (int b = 0; b < 6; b++) block_random();

        block_const(12'hFFF);
`ifdef WHEEL_CLAMP_EN
        check_eq("clamp_top", 32'(wheel), 32'd3855);
`else
        check_eq("clamp_top", 32'(wheel), 32'd4095);
`endif

        // reset while waiting for a response
        for (int i = 0; i < 3; i++) convert(12'h200, 0, 1);
        wait_cmd();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b0;
        rsp_valid = 1'b1; rsp_channel = P_CH; rsp_data = 12'h800;
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        check_eq("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("mid_rst_wheel", 32'(wheel), 32'd0);
        check_eq("mid_rst_upd", 32'(wheel_upd), 32'd0);
        check_eq("mid_rst_timeout", 32'(timeout_cnt), 32'd0);
        @(negedge clk);
        rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("late_rsp_wheel", 32'(wheel), 32'd0);
        check_eq("late_rsp_upd", 32'(upd_count), 32'(exp_cnt));
        block_random();
        block_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
